frame_capture_buffer: RTL and testbench
=======================================

Name: frame_capture_buffer

Overview:
Parametrised, double-buffered input stage for the digit classifier. It captures a frame of NUM_ROWS rows, each ROW_W bits wide, streamed one row per cycle under data_read. Each completed frame is presented to the inference core with a valid/ready handshake, so the next frame can load while the current one is being classified. It adds gap-timeout framing-error detection and overflow accounting, which the current single-frame input path lacks.

Parameters:
ROW_W, 16, bits per image row
NUM_ROWS, 16, rows per frame
GAP_MAX, 4, idle cycles allowed mid-frame before abort; 0 disables the timeout
CNT_W, 8, width of the saturating drop counter

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous, active-low reset
data_in  in  ROW_W  pixel row, MSB = leftmost pixel
data_read  in  1  row strobe; a row is captured on every posedge where data_read=1 and in_ready=1
in_ready  out  1  write bank free; rows are accepted
row_idx  out  clog2(NUM_ROWS)  index of the next row to be written
frame_data  out  ROW_W*NUM_ROWS  read bank; first received row occupies the MSBs
frame_valid  out  1  read bank holds a complete frame
frame_ready  in  1  consumer accepts the frame
frame_err  out  1  one-cycle pulse on gap-timeout abort
drop_cnt  out  CNT_W  saturating count of rows presented while in_ready=0

Behaviour:
- Reset (rst=0, asynchronous): both banks marked empty, wr_sel=0, rd_sel=0, row_idx=0, gap counter=0, frame_err=0, drop_cnt=0, frame_valid=0, in_ready=1. frame_data contents are don't-care, but the bank registers reset to 0.
- Storage: two banks, A and B, each with a full flag. Writer targets bank[wr_sel]; reader presents bank[rd_sel].
- in_ready = !full[wr_sel] (combinational from registers).
- Capture: when data_read=1 and in_ready=1, data_in is written to row row_idx of bank[wr_sel].
  - Row 0 lands at bits [ROW_W*NUM_ROWS-1 -: ROW_W].
  - row_idx increments on each capture.
- Completion: a capture with row_idx==NUM_ROWS-1 sets full[wr_sel], toggles wr_sel, and resets row_idx to 0.
  - frame_valid is registered and goes high in the cycle after the capture edge of the last row (1-cycle latency), provided that bank is rd_sel.
- Reader: frame_valid = full[rd_sel]; frame_data = bank[rd_sel].
  - frame_data is stable while frame_valid=1 and frame_ready=0.
  - On frame_valid&frame_ready at the clock edge: clear full[rd_sel] and toggle rd_sel.
  - Back-to-back frames: frame_valid stays high if the other bank is already full.
- Writer FSM:
  - IDLE (row_idx==0): data_read=1 with in_ready=1 goes to FILL.
  - FILL: each capture increments row_idx. The cycle with data_read=0 increments the gap counter; a capture clears it.
    - Gap counter reaching GAP_MAX (GAP_MAX>0) → ABORT.
    - Completion → IDLE.
  - ABORT (one cycle): frame_err=1, row_idx=0, gap counter=0, partial bank not marked full. Returns to IDLE. A data_read in the ABORT cycle is ignored and not counted as a drop.
- Overflow: data_read=1 with in_ready=0 drops the row, and drop_cnt increments (saturates at 2^CNT_W-1). row_idx does not change. The gap counter does not run while in_ready=0.
- Simultaneous events:
  - Completion into bank X in the same cycle as a pop from bank Y: both take effect.
  - Pop of a bank in the same cycle it becomes writable: in_ready rises the next cycle. There is no same-cycle pass-through.
- Reset mid-frame or mid-handshake: everything clears immediately and any partial or pending frame is lost. No frame_err is raised.
- NUM_ROWS must be ≥2; ROW_W ≥1.

Decomposition:
- Package fcb_pkg:
  - default ROW_W/NUM_ROWS
  - ROW_IDX_W = $clog2(NUM_ROWS)
  - FRAME_W = ROW_W*NUM_ROWS
  - writer state enum {IDLE, FILL, ABORT}
- Sub-module fcb_bank: one frame of storage with a row write port (we, row index, row data), a full-frame read output, and an async active-low clear. It is instantiated twice. The top holds the FSM, flags, and counters.

Test Plan:
- Load the "1" digit (16 rows, first 16'h0007, last 16'h0004), frame_ready=1 → frame_valid for exactly 1 cycle, 1 cycle after the 16th capture. frame_data[255:240]=16'h0007, [15:0]=16'h0004.
- Two frames back-to-back with frame_ready=0 → in_ready=0 after the 32nd row. A 33rd row gives drop_cnt=1. Asserting frame_ready pops frame 1 then frame 2 in order, and in_ready returns 1 the cycle after the first pop.
- Send 5 rows, then data_read=0 for 4 cycles (GAP_MAX=4) → frame_err pulses once, row_idx=0. The next full 16-row frame is captured correctly, with its first row at the MSBs.
- Gap of 3 cycles mid-frame → no frame_err, the frame completes normally with all 16 rows intact.
- Drive rst=0 asynchronously after row 9 → outputs clear without waiting for a clock edge. A subsequent full frame is captured as rows 0..15.
- CNT_W=2: drop 5 rows while full → drop_cnt saturates at 3.

Source files
------------

// File: rtl/fcb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fcb_pkg: shared widths and writer state type for frame_capture_buffer |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fcb_pkg;

  localparam int c_def_row_w    = 16;
  localparam int c_def_num_rows = 16;
  localparam int c_row_idx_w    = $clog2(c_def_num_rows);
  localparam int c_frame_w      = c_def_row_w * c_def_num_rows;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ABORT = 2'd2
  } wr_state_t;

  // Index width that stays legal even for degenerate row counts.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fcb_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fcb_bank: one frame of row storage, row write port, full-frame read   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fcb_bank #(
  parameter int ROW_W    = 16,
  parameter int NUM_ROWS = 16,
  parameter int IDX_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [IDX_W-1:0]          row_idx,
  input  logic [ROW_W-1:0]          row_data,
  output logic [ROW_W*NUM_ROWS-1:0] frame
);

  localparam int c_frame_w = ROW_W * NUM_ROWS;

  logic [ROW_W-1:0] r_mem [NUM_ROWS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ROWS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[row_idx] <= row_data;
    end
  end

  // Row 0 is the first row received and sits in the most significant slot.
  generate
    for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
      assign frame[c_frame_w-1-i*ROW_W -: ROW_W] = r_mem[i];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/frame_capture_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_capture_buffer: double-buffered row capture with valid/ready    |
// | output, gap-timeout abort and saturating drop counter                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module frame_capture_buffer
  import fcb_pkg::*;
#(
  parameter int ROW_W    = c_def_row_w,
  parameter int NUM_ROWS = c_def_num_rows,
  parameter int GAP_MAX  = 4,
  parameter int CNT_W    = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [ROW_W-1:0]                    data_in,
  input  logic                                data_read,
  output logic                                in_ready,
  output logic [idx_width(NUM_ROWS)-1:0]      row_idx,
  output logic [ROW_W*NUM_ROWS-1:0]           frame_data,
  output logic                                frame_valid,
  input  logic                                frame_ready,
  output logic                                frame_err,
  output logic [CNT_W-1:0]                    drop_cnt
);

  localparam int                   c_idx_w    = idx_width(NUM_ROWS);
  localparam int                   c_fw       = ROW_W * NUM_ROWS;
  localparam int                   c_gap_w    = $clog2(GAP_MAX + 2);
  localparam logic [c_idx_w-1:0]   c_last_row = c_idx_w'(NUM_ROWS - 1);
  localparam logic [c_gap_w-1:0]   c_gap_lim  = c_gap_w'(GAP_MAX);
  localparam logic [CNT_W-1:0]     c_cnt_max  = '1;

  wr_state_t            r_state;
  logic [1:0]           r_full;
  logic                 r_wr_sel;
  logic                 r_rd_sel;
  logic [c_idx_w-1:0]   r_row_idx;
  logic [c_gap_w-1:0]   r_gap;
  logic                 r_frame_err;
  logic [CNT_W-1:0]     r_drop_cnt;

  logic                 w_in_ready;
  logic                 w_capture;
  logic                 w_drop;
  logic                 w_last;
  logic                 w_pop;
  logic                 w_gap_tick;
  logic                 w_timeout;
  logic [1:0]           w_set;
  logic [1:0]           w_clr;
  logic [c_fw-1:0]      w_bank_data [2];

  assign w_in_ready = !r_full[r_wr_sel];
  // Rows arriving in the abort cycle are discarded outright, not counted.
  assign w_capture  = data_read && w_in_ready && (r_state != ABORT);
  assign w_drop     = data_read && !w_in_ready && (r_state != ABORT);
  assign w_last     = w_capture && (r_row_idx == c_last_row);
  assign w_pop      = r_full[r_rd_sel] && frame_ready;
  assign w_gap_tick = (r_state == FILL) && !data_read && w_in_ready;
  assign w_timeout  = w_gap_tick && (GAP_MAX > 0) && (r_gap == c_gap_lim - 1'b1);
  assign w_set      = w_last ? (2'b01 << r_wr_sel) : 2'b00;
  assign w_clr      = w_pop  ? (2'b01 << r_rd_sel) : 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_full      <= 2'b00;
      r_wr_sel    <= 1'b0;
      r_rd_sel    <= 1'b0;
      r_row_idx   <= '0;
      r_gap       <= '0;
      r_frame_err <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_frame_err <= 1'b0;
      r_full      <= (r_full | w_set) & ~w_clr;
      if (w_pop) begin
        r_rd_sel <= ~r_rd_sel;
      end
      if (w_drop && (r_drop_cnt != c_cnt_max)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_capture) begin
            r_row_idx <= r_row_idx + 1'b1;
            r_gap     <= '0;
            r_state   <= FILL;
          end
        end
        FILL: begin
          if (w_capture) begin
            r_gap <= '0;
            if (w_last) begin
              r_row_idx <= '0;
              r_wr_sel  <= ~r_wr_sel;
              r_state   <= IDLE;
            end else begin
              r_row_idx <= r_row_idx + 1'b1;
            end
          end else if (w_timeout) begin
            r_state     <= ABORT;
            r_frame_err <= 1'b1;
            r_row_idx   <= '0;
            r_gap       <= '0;
          end else if (w_gap_tick && (GAP_MAX > 0)) begin
            r_gap <= r_gap + 1'b1;
          end
        end
        ABORT: begin
          r_state   <= IDLE;
          r_row_idx <= '0;
          r_gap     <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      fcb_bank #(
        .ROW_W    (ROW_W),
        .NUM_ROWS (NUM_ROWS),
        .IDX_W    (c_idx_w)
      ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .we       (w_capture && (r_wr_sel == 1'(b))),
        .row_idx  (r_row_idx),
        .row_data (data_in),
        .frame    (w_bank_data[b])
      );
    end
  endgenerate

  assign in_ready    = w_in_ready;
  assign row_idx     = r_row_idx;
  assign frame_valid = r_full[r_rd_sel];
  assign frame_data  = r_rd_sel ? w_bank_data[1] : w_bank_data[0];
  assign frame_err   = r_frame_err;
  assign drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_capture_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_frame_capture_buffer: directed bench with a frame-queue model      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_frame_capture_buffer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [15:0]  data_in = '0;
  logic         data_read = 1'b0;
  logic         frame_ready = 1'b0;

  logic         in_ready, frame_valid, frame_err;
  logic [3:0]   row_idx;
  logic [255:0] frame_data;
  logic [7:0]   drop_cnt;

  logic         in_ready2, frame_valid2, frame_err2;
  logic [3:0]   row_idx2;
  logic [255:0] frame_data2;
  logic [1:0]   drop_cnt2;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  frame_capture_buffer #(.ROW_W(16), .NUM_ROWS(16), .GAP_MAX(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_read(data_read),
    .in_ready(in_ready), .row_idx(row_idx), .frame_data(frame_data),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_err(frame_err), .drop_cnt(drop_cnt)
  );

  frame_capture_buffer #(.ROW_W(16), .NUM_ROWS(16), .GAP_MAX(4), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .data_in(data_in), .data_read(data_read),
    .in_ready(in_ready2), .row_idx(row_idx2), .frame_data(frame_data2),
    .frame_valid(frame_valid2), .frame_ready(frame_ready),
    .frame_err(frame_err2), .drop_cnt(drop_cnt2)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: completed frames form a queue of depth two; the partial frame is
  // built by shifting rows in, so the first row ends up at the top.
  logic [255:0] q[$];
  logic [255:0] m_part;
  int           m_rows, m_gap, m_drops;
  bit           m_abort;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        q.delete();
        m_part = '0; m_rows = 0; m_gap = 0; m_drops = 0; m_abort = 0;
      end else begin
        bit rdy, pop, push, ab;
        rdy  = (q.size() < 2);
        pop  = (q.size() > 0) && frame_ready;
        push = 0;
        ab   = 0;
        if (m_abort) begin
          m_rows = 0; m_gap = 0;
        end else if (data_read && rdy) begin
          m_part = {m_part[239:0], data_in};
          m_rows++;
          m_gap = 0;
          if (m_rows == 16) begin
            push = 1; m_rows = 0;
          end
        end else if (data_read) begin
          m_drops++;
        end else if (m_rows > 0) begin
          m_gap++;
          if (m_gap == 4) begin
            ab = 1; m_rows = 0; m_gap = 0;
          end
        end
        if (pop) void'(q.pop_front());
        if (push) q.push_back(m_part);
        m_abort = ab;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("in_ready",    256'(in_ready),    256'(q.size() < 2));
        chk("row_idx",     256'(row_idx),     256'(m_rows));
        chk("frame_valid", 256'(frame_valid), 256'(q.size() > 0));
        chk("frame_err",   256'(frame_err),   256'(m_abort));
        chk("drop_cnt",    256'(drop_cnt),    256'((m_drops > 255) ? 255 : m_drops));
        chk("drop_cnt_w2", 256'(drop_cnt2),   256'((m_drops > 3) ? 3 : m_drops));
        if (q.size() > 0) chk("frame_data", frame_data, q[0]);
      end
    end
  end

  task automatic cyc(input logic rd, input logic [15:0] d);
    @(negedge clk);
    #1;
    data_read = rd;
    data_in   = d;
  endtask

  task automatic send_frame(input logic [7:0] tag);
    for (int i = 0; i < 16; i++) cyc(1'b1, {tag, 8'(i)});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready",    256'(in_ready),    256'(1));
    chk("rst_frame_valid", 256'(frame_valid), 256'(0));
    chk("rst_row_idx",     256'(row_idx),     256'(0));
    chk("rst_drop_cnt",    256'(drop_cnt),    256'(0));
    chk("rst_frame_err",   256'(frame_err),   256'(0));
    rst = 1'b1;

    // "1" digit, consumer always ready
    frame_ready = 1'b1;
    for (int i = 0; i < 16; i++)
      cyc(1'b1, (i == 0) ? 16'h0007 : ((i == 15) ? 16'h0004 : 16'h0002));
    cyc(1'b0, 16'h0);
    chk("digit_valid", 256'(frame_valid), 256'(1));
    chk("digit_top",   256'(frame_data[255:240]), 256'(16'h0007));
    chk("digit_bot",   256'(frame_data[15:0]),    256'(16'h0004));
    cyc(1'b0, 16'h0);
    chk("digit_valid_once", 256'(frame_valid), 256'(0));

    // two frames held, one overflow row, then in-order drain
    frame_ready = 1'b0;
    send_frame(8'hA1);
    send_frame(8'hB2);
    cyc(1'b0, 16'h0);
    chk("both_full_in_ready", 256'(in_ready), 256'(0));
    chk("held_first",         256'(frame_data[255:240]), 256'(16'hA100));
    cyc(1'b1, 16'hDEAD);
    cyc(1'b0, 16'h0);
    chk("drop_one", 256'(drop_cnt), 256'(1));
    frame_ready = 1'b1;
    cyc(1'b0, 16'h0);
    chk("after_pop_in_ready", 256'(in_ready), 256'(1));
    chk("second_top",         256'(frame_data[255:240]), 256'(16'hB200));
    chk("second_bot",         256'(frame_data[15:0]),    256'(16'hB20F));
    cyc(1'b0, 16'h0);
    chk("drained", 256'(frame_valid), 256'(0));

    // saturation of the narrow counter
    frame_ready = 1'b0;
    send_frame(8'hC1);
    send_frame(8'hC2);
    repeat (5) cyc(1'b1, 16'hBEEF);
    cyc(1'b0, 16'h0);
    chk("sat_w2", 256'(drop_cnt2), 256'(3));
    chk("sat_w8", 256'(drop_cnt),  256'(6));
    frame_ready = 1'b1;
    repeat (3) cyc(1'b0, 16'h0);

    // gap timeout aborts a 5-row partial frame
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'hEE00 + 16'(i));
    repeat (4) cyc(1'b0, 16'h0);
    cyc(1'b1, 16'hFFFF);
    chk("abort_err",     256'(frame_err), 256'(1));
    chk("abort_row_idx", 256'(row_idx),   256'(0));
    cyc(1'b0, 16'h0);
    chk("abort_err_pulse", 256'(frame_err), 256'(0));
    chk("abort_no_drop",   256'(drop_cnt),  256'(6));
    send_frame(8'h33);
    cyc(1'b0, 16'h0);
    chk("post_abort_top", 256'(frame_data[255:240]), 256'(16'h3300));
    chk("post_abort_bot", 256'(frame_data[15:0]),    256'(16'h330F));
    cyc(1'b0, 16'h0);

    // gap of 3 is tolerated
    for (int i = 0; i < 8; i++) cyc(1'b1, {8'h44, 8'(i)});
    repeat (3) cyc(1'b0, 16'h0);
    for (int i = 8; i < 16; i++) cyc(1'b1, {8'h44, 8'(i)});
    cyc(1'b0, 16'h0);
    chk("gap3_valid", 256'(frame_valid), 256'(1));
    chk("gap3_row8",  256'(frame_data[127:112]), 256'(16'h4408));
    cyc(1'b0, 16'h0);

    // asynchronous reset with one pending frame and a partial frame
    frame_ready = 1'b0;
    send_frame(8'hD1);
    for (int i = 0; i < 9; i++) cyc(1'b1, {8'hD2, 8'(i)});
    @(negedge clk);
    #3;
    data_read = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_valid",    256'(frame_valid), 256'(0));
    chk("async_row_idx",  256'(row_idx),     256'(0));
    chk("async_in_ready", 256'(in_ready),    256'(1));
    chk("async_drop",     256'(drop_cnt),    256'(0));
    rst = 1'b1;
    frame_ready = 1'b1;
    send_frame(8'h55);
    cyc(1'b0, 16'h0);
    chk("post_rst_top", 256'(frame_data[255:240]), 256'(16'h5500));
    chk("post_rst_bot", 256'(frame_data[15:0]),    256'(16'h550F));
    repeat (2) cyc(1'b0, 16'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
